// File: rtl/beehive_vr_pkg.sv
// ---------------------------------------------------------------------------
// beehive_vr_pkg
// Shared definitions for the VR prepare log writer slice.
//   INT_W             : width of byte-length fields carried with a Prepare.
//   LOG_DEPTH_W       : default log data memory address width.
//   PREPARE_HDR_BYTES : default size of the prepare header at the top of flit 0.
//   vr_wr_state_e     : log writer FSM state encoding.
//   vr_log_wr_req     : start request as seen by the log writer.
// ---------------------------------------------------------------------------
package beehive_vr_pkg;

    localparam int INT_W             = 32;
    localparam int LOG_DEPTH_W       = 10;
    localparam int PREPARE_HDR_BYTES = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIRST,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } vr_wr_state_e;

    typedef struct packed {
        logic [LOG_DEPTH_W-1:0] addr;
        logic [INT_W-1:0]       payload_len;
    } vr_log_wr_req;

endpackage

// File: rtl/vr_realign_merge.sv
// ---------------------------------------------------------------------------
// vr_realign_merge
// Builds one log line from the payload bytes held over from the previous flit
// (carry) and the leading header-sized slice of the current flit (head), then
// zeroes the bytes past the end of the payload when this is the final line.
// Purely combinational.
// Ports:
//   i_carry    : low (B - PREP_HDR_BYTES) bytes of the previous flit.
//   i_head     : top PREP_HDR_BYTES bytes of the current flit.
//   i_use_head : 1 = append i_head, 0 = append zeros (draining the carry).
//   i_mask_en  : this line is the last line of the payload.
//   i_rem      : payload length mod B; 0 means the last line is full.
//   o_data     : assembled log line, byte 0 at the MSBs.
// ---------------------------------------------------------------------------
module vr_realign_merge
    import beehive_vr_pkg::*;
#(
    parameter int NOC_DATA_W     = 512,
    parameter int PREP_HDR_BYTES = PREPARE_HDR_BYTES
) (
    input  logic [NOC_DATA_W-PREP_HDR_BYTES*8-1:0] i_carry,
    input  logic [PREP_HDR_BYTES*8-1:0]            i_head,
    input  logic                                   i_use_head,
    input  logic                                   i_mask_en,
    input  logic [$clog2(NOC_DATA_W/8)-1:0]        i_rem,
    output logic [NOC_DATA_W-1:0]                  o_data
);

    localparam int NB     = NOC_DATA_W / 8;
    localparam int HEAD_W = PREP_HDR_BYTES * 8;

    logic [HEAD_W-1:0]     w_head_sel;
    logic [NOC_DATA_W-1:0] w_raw;

    assign w_head_sel = i_use_head ? i_head : '0;
    assign w_raw      = {i_carry, w_head_sel};

    // A remainder of zero means the payload ends exactly on a line boundary,
    // so nothing in the final line needs clearing.
    always_comb begin
        o_data = w_raw;
        if (i_mask_en && (i_rem != '0)) begin
            for (int j = 0; j < NB; j++) begin
                if (j >= int'(i_rem)) begin
                    o_data[NOC_DATA_W-1-8*j -: 8] = 8'h00;
                end
            end
        end
    end

endmodule

// File: rtl/vr_prep_log_writer.sv
// ---------------------------------------------------------------------------
// vr_prep_log_writer
// Streams the payload of an accepted Prepare from the NoC data bus into the
// log data memory, one line per write. Flit 0 carries the prepare header in
// its top PREP_HDR_BYTES, so every line is stitched from the tail of one flit
// and the head of the next. Reports the number of lines written when done.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset.
//   i_start_val / o_start_rdy   : start request (rdy only while idle).
//   i_start_wr_addr             : first log line address.
//   i_start_payload_len         : payload bytes, header excluded.
//   i_noc_data_*  / o_noc_data_rdy : NoC flit stream (padbytes unused).
//   o_log_wr_val / i_log_wr_rdy : log memory write handshake.
//   o_log_wr_addr, o_log_wr_data: log memory write address and line.
//   o_done_val / i_done_rdy     : completion handshake.
//   o_done_lines                : number of lines actually written.
//   o_done_err                  : stream ended before all needed flits.
// ---------------------------------------------------------------------------
module vr_prep_log_writer
    import beehive_vr_pkg::*;
#(
    parameter int NOC_DATA_W     = 512,
    parameter int NOC_PADBYTES_W = 6,
    parameter int LOG_DEPTH_W    = 10,
    parameter int PREP_HDR_BYTES = PREPARE_HDR_BYTES
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      i_start_val,
    output logic                      o_start_rdy,
    input  logic [LOG_DEPTH_W-1:0]    i_start_wr_addr,
    input  logic [INT_W-1:0]          i_start_payload_len,

    input  logic                      i_noc_data_val,
    output logic                      o_noc_data_rdy,
    input  logic [NOC_DATA_W-1:0]     i_noc_data,
    input  logic                      i_noc_data_last,
    input  logic [NOC_PADBYTES_W-1:0] i_noc_data_padbytes,

    output logic                      o_log_wr_val,
    input  logic                      i_log_wr_rdy,
    output logic [LOG_DEPTH_W-1:0]    o_log_wr_addr,
    output logic [NOC_DATA_W-1:0]     o_log_wr_data,

    output logic                      o_done_val,
    input  logic                      i_done_rdy,
    output logic [LOG_DEPTH_W:0]      o_done_lines,
    output logic                      o_done_err
);

    localparam int NB      = NOC_DATA_W / 8;
    localparam int BSH     = $clog2(NB);
    localparam int HEAD_W  = PREP_HDR_BYTES * 8;
    localparam int CARRY_W = NOC_DATA_W - HEAD_W;
    localparam int CNT_W   = LOG_DEPTH_W + 1;
    localparam int LEN_X_W = INT_W + 1;

    vr_wr_state_e           r_state;
    vr_wr_state_e           w_state_nxt;

    logic [LOG_DEPTH_W-1:0] r_addr;
    logic [CNT_W-1:0]       r_lines;
    logic [CNT_W-1:0]       r_flits;
    logic [CNT_W-1:0]       r_lines_wr;
    logic [CNT_W-1:0]       r_flit_cnt;
    logic [CARRY_W-1:0]     r_carry;
    logic [BSH-1:0]         r_rem;
    logic                   r_err;

    vr_log_wr_req           w_req;
    logic [LEN_X_W-1:0]     w_len_x;
    logic [CNT_W-1:0]       w_lines_calc;
    logic [CNT_W-1:0]       w_flits_calc;
    logic [BSH-1:0]         w_rem_calc;

    logic [HEAD_W-1:0]      w_flit_head;
    logic [CARRY_W-1:0]     w_flit_tail;
    logic [CNT_W-1:0]       w_lines_wr_inc;
    logic [CNT_W-1:0]       w_flit_cnt_inc;
    logic                   w_need_line;
    logic                   w_final_line;

    logic                   w_noc_rdy;
    logic                   w_log_wr_val;
    logic                   w_use_head;
    logic                   w_start_fire;
    logic                   w_flit_acc;
    logic                   w_wr_fire;
    logic [NOC_DATA_W-1:0]  w_merged;
    logic                   w_unused;

    // Message length is taken from the start request, never from padbytes.
    assign w_unused = ^i_noc_data_padbytes;

    // Line and flit counts are derived once at start. The extra bit on the
    // length keeps the round-up addition from overflowing before the shift.
    assign w_req        = '{addr: i_start_wr_addr, payload_len: i_start_payload_len};
    assign w_len_x      = LEN_X_W'(w_req.payload_len);
    assign w_lines_calc = CNT_W'((w_len_x + LEN_X_W'(NB - 1)) >> BSH);
    assign w_flits_calc = CNT_W'((w_len_x + LEN_X_W'(PREP_HDR_BYTES + NB - 1)) >> BSH);
    assign w_rem_calc   = w_req.payload_len[BSH-1:0];

    assign w_flit_head    = i_noc_data[NOC_DATA_W-1 -: HEAD_W];
    assign w_flit_tail    = i_noc_data[CARRY_W-1:0];
    assign w_lines_wr_inc = r_lines_wr + CNT_W'(1);
    assign w_flit_cnt_inc = r_flit_cnt + CNT_W'(1);
    assign w_need_line    = (r_lines_wr < r_lines);
    assign w_final_line   = (w_lines_wr_inc == r_lines);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake outputs. In STREAM a flit that still owes a
    // line is only taken together with its write, so the NoC ready mirrors
    // the log ready; surplus flits past the last line are swallowed freely.
    always_comb begin
        w_state_nxt  = r_state;
        o_start_rdy  = 1'b0;
        w_noc_rdy    = 1'b0;
        w_log_wr_val = 1'b0;
        w_use_head   = 1'b0;
        o_done_val   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_start_rdy = 1'b1;
                if (i_start_val) begin
                    w_state_nxt = ST_FIRST;
                end
            end
            ST_FIRST: begin
                w_noc_rdy = 1'b1;
                if (i_noc_data_val) begin
                    if (i_noc_data_last) begin
                        w_state_nxt = (r_lines == '0) ? ST_DONE : ST_DRAIN;
                    end else begin
                        w_state_nxt = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                w_use_head   = 1'b1;
                w_log_wr_val = i_noc_data_val && w_need_line;
                w_noc_rdy    = w_need_line ? i_log_wr_rdy : 1'b1;
                if (i_noc_data_val && w_noc_rdy && i_noc_data_last) begin
                    if (w_need_line && (w_lines_wr_inc < r_lines)) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DRAIN: begin
                w_log_wr_val = 1'b1;
                if (i_log_wr_rdy) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done_val = 1'b1;
                if (i_done_rdy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_start_fire = (r_state == ST_IDLE) && i_start_val;
    assign w_flit_acc   = i_noc_data_val && w_noc_rdy;
    assign w_wr_fire    = w_log_wr_val && i_log_wr_rdy;

    // Message context, carry and progress counters. An early last is flagged
    // when the accepted flit count falls short of what the length requires;
    // whatever lines were formed still go out and the carry is drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_lines    <= '0;
            r_flits    <= '0;
            r_lines_wr <= '0;
            r_flit_cnt <= '0;
            r_carry    <= '0;
            r_rem      <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_start_fire) begin
                r_addr     <= w_req.addr;
                r_lines    <= w_lines_calc;
                r_flits    <= w_flits_calc;
                r_rem      <= w_rem_calc;
                r_lines_wr <= '0;
                r_flit_cnt <= '0;
                r_carry    <= '0;
                r_err      <= 1'b0;
            end
            if (w_flit_acc) begin
                r_flit_cnt <= w_flit_cnt_inc;
                if ((r_state == ST_FIRST) || w_need_line) begin
                    r_carry <= w_flit_tail;
                end
                if (i_noc_data_last && (w_flit_cnt_inc < r_flits)) begin
                    r_err <= 1'b1;
                end
            end
            if (w_wr_fire) begin
                r_addr     <= r_addr + LOG_DEPTH_W'(1);
                r_lines_wr <= w_lines_wr_inc;
            end
        end
    end

    vr_realign_merge #(
        .NOC_DATA_W     (NOC_DATA_W),
        .PREP_HDR_BYTES (PREP_HDR_BYTES)
    ) u_merge (
        .i_carry    (r_carry),
        .i_head     (w_flit_head),
        .i_use_head (w_use_head),
        .i_mask_en  (w_final_line),
        .i_rem      (r_rem),
        .o_data     (w_merged)
    );

    assign o_noc_data_rdy = w_noc_rdy;
    assign o_log_wr_val   = w_log_wr_val;
    assign o_log_wr_addr  = r_addr;
    assign o_log_wr_data  = w_log_wr_val ? w_merged : '0;
    assign o_done_lines   = r_lines_wr;
    assign o_done_err     = r_err;

endmodule

// File: tb/tb_vr_prep_log_writer.sv
// ---------------------------------------------------------------------------
// tb_vr_prep_log_writer
// Drives whole Prepare messages into vr_prep_log_writer and compares every
// log write and completion against a byte-level model: the payload is the
// flit byte stream from offset HDR onward, line k holds payload bytes
// k*B..k*B+B-1, and any byte past the length or past the bytes actually
// delivered reads as zero.
// ---------------------------------------------------------------------------
module tb_vr_prep_log_writer;

    localparam int DW   = 512;
    localparam int NB   = 64;
    localparam int HDR  = 32;
    localparam int AW   = 10;
    localparam int MAXF = 16;

    logic            clk;
    logic            rst_n;
    logic            startVal;
    logic            startRdy;
    logic [AW-1:0]   startAddr;
    logic [31:0]     startLen;
    logic            nocVal;
    logic            nocRdy;
    logic [DW-1:0]   nocData;
    logic            nocLast;
    logic [5:0]      nocPad;
    logic            logVal;
    logic            logRdy;
    logic [AW-1:0]   logAddr;
    logic [DW-1:0]   logData;
    logic            doneVal;
    logic            doneRdy;
    logic [AW:0]     doneLines;
    logic            doneErr;

    int              assertCount;
    int              failCount;
    logic [7:0]      streamBytes [0:MAXF*NB-1];

    vr_prep_log_writer dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_start_val         (startVal),
        .o_start_rdy         (startRdy),
        .i_start_wr_addr     (startAddr),
        .i_start_payload_len (startLen),
        .i_noc_data_val      (nocVal),
        .o_noc_data_rdy      (nocRdy),
        .i_noc_data          (nocData),
        .i_noc_data_last     (nocLast),
        .i_noc_data_padbytes (nocPad),
        .o_log_wr_val        (logVal),
        .i_log_wr_rdy        (logRdy),
        .o_log_wr_addr       (logAddr),
        .o_log_wr_data       (logData),
        .o_done_val          (doneVal),
        .i_done_rdy          (doneRdy),
        .o_done_lines        (doneLines),
        .o_done_err          (doneErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Flit f of the current message, byte 0 at the MSBs.
    function automatic logic [DW-1:0] flitWord(input int f);
        logic [DW-1:0] w;
        w = '0;
        for (int j = 0; j < NB; j++) begin
            w[DW-1-8*j -: 8] = streamBytes[f*NB + j];
        end
        return w;
    endfunction

    // Expected log line k: payload byte q sits at stream offset HDR+q.
    function automatic logic [DW-1:0] modelLine(input int k, input int len, input int avail);
        logic [DW-1:0] d;
        int q;
        d = '0;
        for (int j = 0; j < NB; j++) begin
            q = k*NB + j;
            if ((q < len) && (q < avail)) begin
                d[DW-1-8*j -: 8] = streamBytes[HDR + q];
            end
        end
        return d;
    endfunction

    // Run one message. mode: 0 = log always ready, 1 = random log ready,
    // 2 = log ready held low for 5 cycles ahead of every write.
    // abortAfter >= 0 stops driving once that many flits were accepted.
    task automatic applyStimulus(input int len, input int addr, input int nFlits,
                                 input int mode, input int abortAfter);
        int needF;
        int lines;
        int avail;
        int nWrites;
        int fIdx;
        int wIdx;
        int stallCnt;
        int cycles;
        bit expErr;
        bit finished;
        bit prevStall;
        logic [AW-1:0] prevAddr;
        logic [DW-1:0] prevData;

        for (int i = 0; i < nFlits*NB; i++) begin
            streamBytes[i] = 8'($urandom);
        end
        needF   = (len + HDR + NB - 1) / NB;
        lines   = (len + NB - 1) / NB;
        avail   = nFlits*NB - HDR;
        nWrites = (avail < len) ? (avail + NB - 1) / NB : lines;
        expErr  = (nFlits < needF);

        @(negedge clk);
        startVal  = 1'b1;
        startAddr = AW'(addr);
        startLen  = 32'(len);
        cycles    = 0;
        #1;
        while (!startRdy && cycles < 50) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        checkOutput("start_rdy", DW'(startRdy), DW'(1));
        @(negedge clk);
        startVal = 1'b0;
        #1;
        checkOutput("start_rdy_busy", DW'(startRdy), DW'(0));

        fIdx      = 0;
        wIdx      = 0;
        stallCnt  = 0;
        prevStall = 1'b0;
        finished  = 1'b0;
        cycles    = 0;
        prevAddr  = '0;
        prevData  = '0;
        while (!finished && cycles < 3000) begin
            if ((abortAfter >= 0) && (fIdx >= abortAfter)) begin
                break;
            end
            nocVal  = (fIdx < nFlits);
            nocData = (fIdx < nFlits) ? flitWord(fIdx) : '0;
            nocLast = (fIdx == nFlits - 1);
            nocPad  = 6'($urandom);
            case (mode)
                0:       logRdy = 1'b1;
                1:       logRdy = ($urandom_range(0, 3) != 0);
                default: logRdy = (stallCnt >= 5);
            endcase
            doneRdy = (mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
            #1;
            if (prevStall) begin
                checkOutput("stall_addr", DW'(logAddr), DW'(prevAddr));
                checkOutput("stall_data", logData, prevData);
            end
            prevStall = 1'b0;
            if (logVal && !logRdy) begin
                checkOutput("stall_noc_rdy", DW'(nocRdy), DW'(0));
                prevStall = 1'b1;
                prevAddr  = logAddr;
                prevData  = logData;
                stallCnt++;
            end
            if (logVal && logRdy) begin
                if (wIdx < nWrites) begin
                    checkOutput("wr_addr", DW'(logAddr), DW'((addr + wIdx) % 1024));
                    checkOutput("wr_data", logData, modelLine(wIdx, len, avail));
                end else begin
                    checkOutput("extra_write", DW'(wIdx + 1), DW'(nWrites));
                end
                wIdx++;
                stallCnt = 0;
            end
            if (nocVal && nocRdy) begin
                fIdx++;
            end
            if (doneVal && doneRdy) begin
                checkOutput("done_lines", DW'(doneLines), DW'(nWrites));
                checkOutput("done_err", DW'(doneErr), DW'(expErr));
                checkOutput("write_count", DW'(wIdx), DW'(nWrites));
                finished = 1'b1;
            end
            @(negedge clk);
            cycles++;
        end
        nocVal  = 1'b0;
        nocLast = 1'b0;
        logRdy  = 1'b0;
        doneRdy = 1'b0;
        if (abortAfter < 0) begin
            checkOutput("timeout", DW'(finished), DW'(1));
            #1;
            checkOutput("start_rdy_after_done", DW'(startRdy), DW'(1));
        end
    endtask

    initial begin
        int len;
        int needF;
        int nFlits;
        int choice;
        assertCount = 0;
        failCount   = 0;
        rst_n       = 1'b0;
        startVal    = 1'b0;
        startAddr   = '0;
        startLen    = '0;
        nocVal      = 1'b0;
        nocData     = '0;
        nocLast     = 1'b0;
        nocPad      = '0;
        logRdy      = 1'b0;
        doneRdy     = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_start_rdy", DW'(startRdy), DW'(1));
        checkOutput("rst_noc_rdy", DW'(nocRdy), DW'(0));
        checkOutput("rst_log_val", DW'(logVal), DW'(0));
        checkOutput("rst_log_addr", DW'(logAddr), DW'(0));
        checkOutput("rst_log_data", logData, DW'(0));
        checkOutput("rst_done_val", DW'(doneVal), DW'(0));
        checkOutput("rst_done_lines", DW'(doneLines), DW'(0));
        checkOutput("rst_done_err", DW'(doneErr), DW'(0));
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed messages");
        applyStimulus(100, 'h10, 3, 0, -1);
        applyStimulus(32, 'h20, 1, 0, -1);
        applyStimulus(128, 'h3FF, 3, 0, -1);
        applyStimulus(100, 'h40, 3, 2, -1);
        applyStimulus(200, 'h80, 2, 0, -1);
        applyStimulus(80, 'h90, 2, 1, -1);
        applyStimulus(200, 'hA0, 1, 1, -1);
        applyStimulus(0, 'h50, 1, 0, -1);

        $display("[TB] reset in the middle of a message");
        applyStimulus(200, 'h60, 4, 0, 2);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_start_rdy", DW'(startRdy), DW'(1));
        checkOutput("abort_done_val", DW'(doneVal), DW'(0));
        checkOutput("abort_log_val", DW'(logVal), DW'(0));
        checkOutput("abort_noc_rdy", DW'(nocRdy), DW'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            checkOutput("abort_no_done", DW'(doneVal), DW'(0));
        end
        applyStimulus(64, 'h70, 2, 1, -1);

        $display("[TB] randomized messages");
        for (int m = 0; m < 40; m++) begin
            len    = $urandom_range(0, 400);
            needF  = (len + HDR + NB - 1) / NB;
            choice = $urandom_range(0, 3);
            nFlits = needF;
            if (choice == 2 && needF > 1) begin
                nFlits = $urandom_range(1, needF - 1);
            end else if (choice == 3) begin
                nFlits = needF + 1;
            end
            applyStimulus(len, $urandom_range(0, 1023), nFlits, $urandom_range(0, 2), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
